// File: rtl/bcd_ascii_serializer_pkg.sv
// Shared constants, state type and helpers for the BCD/ASCII conversion paths.
// The ASCII constants are also used by the ASCII-to-BCD receive path.
package bcd_ascii_serializer_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        StIdle,
        StDigit,
        StTermCr,
        StTermLf
    } state_e;

    function automatic logic bcd_nibble_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_ascii_serializer_if.sv
// Valid/ready word-in, byte-out bundle for the BCD-to-ASCII serializer.
interface bcd_ascii_serializer_if #(
    parameter int unsigned NDIG = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*NDIG-1:0]     in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic                  out_last;
    logic                  bcd_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_data, out_last, bcd_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_data, out_last, bcd_err
    );
endinterface

// File: rtl/bcd_ascii_serializer_digit_to_ascii.sv
// Combinational BCD nibble to ASCII character; invalid nibbles become '?' with err set.
module bcd_digit_to_ascii
    import bcd_ascii_serializer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii,
    output logic       err
);

    always_comb begin
        ascii = ASCII_QMARK;
        err   = 1'b1;
        if (bcd_nibble_valid(nibble)) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
            err   = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_ascii_serializer.sv
// Serializes one packed BCD word into ASCII bytes, MSD first, with optional
// leading-zero suppression and CR/LF terminator.
module bcd_ascii_serializer
    import bcd_ascii_serializer_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter bit          LZ_SUPPRESS = 1'b1,
    parameter bit          TERM_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_ascii_serializer_if.slave  bus
);

    state_e             state_q, state_d;
    logic [4*NDIG-1:0]  word_q, word_d;
    // Digits still to be sent after the one currently presented.
    logic [2:0]         rem_q, rem_d;

    logic [4*NDIG-1:0]  in_bcd;
    logic [2:0]         start_idx;

    logic               in_ready;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_last;
    logic               bcd_err;

    logic [7:0]         dig_ascii;
    logic               dig_err;

    assign in_bcd = bus.in_bcd;

    // Highest nonzero (or invalid) digit; digit 0 is always sent.
    always_comb begin
        start_idx = '0;
        if (!LZ_SUPPRESS) begin
            start_idx = 3'(NDIG - 1);
        end else begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (in_bcd[4*i +: 4] != 4'h0) begin
                    start_idx = 3'(i);
                end
            end
        end
    end

    // The current digit always sits in the top nibble of the shift register.
    bcd_digit_to_ascii u_digit (
        .nibble (word_q[4*NDIG-1 -: 4]),
        .ascii  (dig_ascii),
        .err    (dig_err)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        bcd_err   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    // Pre-align so the start digit lands in the top nibble.
                    word_d  = in_bcd << (4 * (NDIG - 1 - 32'(start_idx)));
                    rem_d   = start_idx;
                    state_d = StDigit;
                end
            end

            StDigit: begin
                out_valid = 1'b1;
                out_data  = dig_ascii;
                bcd_err   = dig_err;
                out_last  = (rem_q == 3'd0) && !TERM_EN;
                if (bus.out_ready) begin
                    if (rem_q == 3'd0) begin
                        state_d = TERM_EN ? StTermCr : StIdle;
                    end else begin
                        rem_d  = rem_q - 3'd1;
                        word_d = word_q << 4;
                    end
                end
            end

            StTermCr: begin
                out_valid = 1'b1;
                out_data  = ASCII_CR;
                if (bus.out_ready) begin
                    state_d = StTermLf;
                end
            end

            StTermLf: begin
                out_valid = 1'b1;
                out_data  = ASCII_LF;
                out_last  = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.bcd_err   = bcd_err;

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Randomized and directed bench for bcd_ascii_serializer, three parameter
// variants driven in parallel and checked against a byte-queue model.
module tb_bcd_ascii_serializer;

    localparam int unsigned NDIG = 4;
    localparam int NI = 3;
    localparam bit LZ_CFG   [NI] = '{1'b1, 1'b0, 1'b1};
    localparam bit TERM_CFG [NI] = '{1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid;
    logic [15:0] in_bcd;
    logic        out_ready;

    bcd_ascii_serializer_if #(.NDIG(NDIG)) bus0 ();
    bcd_ascii_serializer_if #(.NDIG(NDIG)) bus1 ();
    bcd_ascii_serializer_if #(.NDIG(NDIG)) bus2 ();

    bcd_ascii_serializer #(.NDIG(NDIG), .LZ_SUPPRESS(1'b1), .TERM_EN(1'b1)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0)
    );
    bcd_ascii_serializer #(.NDIG(NDIG), .LZ_SUPPRESS(1'b0), .TERM_EN(1'b1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );
    bcd_ascii_serializer #(.NDIG(NDIG), .LZ_SUPPRESS(1'b1), .TERM_EN(1'b0)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (bus2)
    );

    assign bus0.in_valid = in_valid;  assign bus0.in_bcd = in_bcd;  assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;  assign bus1.in_bcd = in_bcd;  assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;  assign bus2.in_bcd = in_bcd;  assign bus2.out_ready = out_ready;

    logic       ov [NI];
    logic       ir [NI];
    logic [7:0] od [NI];
    logic       ol [NI];
    logic       oe [NI];
    assign ov[0] = bus0.out_valid; assign ir[0] = bus0.in_ready; assign od[0] = bus0.out_data;
    assign ol[0] = bus0.out_last;  assign oe[0] = bus0.bcd_err;
    assign ov[1] = bus1.out_valid; assign ir[1] = bus1.in_ready; assign od[1] = bus1.out_data;
    assign ol[1] = bus1.out_last;  assign oe[1] = bus1.bcd_err;
    assign ov[2] = bus2.out_valid; assign ir[2] = bus2.in_ready; assign od[2] = bus2.out_data;
    assign ol[2] = bus2.out_last;  assign oe[2] = bus2.bcd_err;

    int n_pass = 0;
    int n_checks = 0;

    // Expected entries are {last, err, byte}.
    logic [9:0] pin_mem [16];
    int         pin_n;
    logic [9:0] exp_mem [NI][16];
    int         exp_cnt [NI];
    int         exp_head [NI];
    logic [7:0] cap [32];
    int         cap_n = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endfunction

    // Frame contents straight from the rules: skip leading zeros, keep digit 0.
    function automatic void build(input logic [15:0] w, input bit lz, input bit term);
        logic       started;
        logic [3:0] nib;
        pin_n   = 0;
        started = !lz;
        for (int d = NDIG - 1; d >= 0; d--) begin
            nib = w[4*d +: 4];
            if (nib != 4'h0 || d == 0) started = 1'b1;
            if (started) begin
                pin_mem[pin_n] = (nib > 4'd9) ? {2'b01, 8'h3F} : {2'b00, 4'h3, nib};
                pin_n++;
            end
        end
        if (term) begin
            pin_mem[pin_n] = {2'b00, 8'h0D}; pin_n++;
            pin_mem[pin_n] = {2'b00, 8'h0A}; pin_n++;
        end
        pin_mem[pin_n-1][9] = 1'b1;
    endfunction

    function automatic logic any_busy();
        logic b = 1'b0;
        for (int i = 0; i < NI; i++) if (exp_head[i] < exp_cnt[i]) b = 1'b1;
        return b;
    endfunction

    // Pins the model against hand-computed frames; errmask bit k flags byte k.
    task automatic pin(input logic [15:0] w, input bit lz, input bit term, input int n,
                       input logic [79:0] bytes, input logic [9:0] errmask);
        build(w, lz, term);
        check($sformatf("pin_len_%h", w), 32'(pin_n), 32'(n));
        for (int k = 0; k < n; k++)
            check($sformatf("pin_%h_b%0d", w, k), 32'(pin_mem[k]),
                  32'({k == n - 1, errmask[k], bytes[8*(n-1-k) +: 8]}));
    endtask

    task automatic check_cap(input string name, input int n, input logic [79:0] bytes);
        check({name, "_count"}, 32'(cap_n), 32'(n));
        for (int k = 0; k < n; k++)
            check($sformatf("%s_b%0d", name, k), 32'(cap[k]), 32'(bytes[8*(n-1-k) +: 8]));
    endtask

    // Compare at the falling edge, then advance the model for the coming rising edge.
    task automatic step();
        logic busy;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            busy = exp_head[i] < exp_cnt[i];
            if (!rst_n) begin
                check($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'(0));
                check($sformatf("rst_ready%0d", i), 32'(ir[i]), 32'(1));
                check($sformatf("rst_data%0d", i), 32'(od[i]), 32'(0));
                check($sformatf("rst_last%0d", i), 32'(ol[i]), 32'(0));
                check($sformatf("rst_err%0d", i), 32'(oe[i]), 32'(0));
                exp_cnt[i]  = 0;
                exp_head[i] = 0;
            end else begin
                check($sformatf("valid%0d", i), 32'(ov[i]), 32'(busy));
                check($sformatf("ready%0d", i), 32'(ir[i]), 32'(!busy));
                if (busy) begin
                    check($sformatf("byte%0d", i), 32'({ol[i], oe[i], od[i]}),
                          32'(exp_mem[i][exp_head[i]]));
                    if (out_ready) begin
                        if (i == 0 && cap_n < 32) begin
                            cap[cap_n] = od[0];
                            cap_n++;
                        end
                        exp_head[i]++;
                    end
                end else if (in_valid) begin
                    build(in_bcd, LZ_CFG[i], TERM_CFG[i]);
                    for (int k = 0; k < pin_n; k++) exp_mem[i][k] = pin_mem[k];
                    exp_cnt[i]  = pin_n;
                    exp_head[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && any_busy(); k++) step();
        check("idle_timeout", 32'(any_busy()), 32'(0));
        step();
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_bcd   = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin exp_cnt[i] = 0; exp_head[i] = 0; end
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        pin(16'h1987, 1'b1, 1'b1, 6, 80'h3139_3837_0D0A, 10'b0);
        pin(16'h0042, 1'b1, 1'b1, 4, 80'h3432_0D0A, 10'b0);
        pin(16'h0042, 1'b0, 1'b1, 6, 80'h3030_3432_0D0A, 10'b0);
        pin(16'h0000, 1'b1, 1'b0, 1, 80'h30, 10'b0);
        pin(16'h1A99, 1'b1, 1'b1, 6, 80'h313F_3939_0D0A, 10'b10);
        pin(16'h0B00, 1'b1, 1'b1, 5, 80'h3F_3030_0D0A, 10'b1);

        step(); step(); step();
        rst_n = 1'b1;
        step();

        // Plan 1-4: consecutive bytes with no backpressure.
        out_ready = 1'b1;
        cap_n = 0;
        send(16'h1987);
        wait_idle();
        check_cap("frame1987", 6, 80'h3139_3837_0D0A);
        send(16'h0042);  wait_idle();
        send(16'h0000);  wait_idle();
        send(16'h1A99);  wait_idle();
        send(16'h0B00);  wait_idle();

        // Plan 5: stall the second byte and poke a word in while busy.
        cap_n = 0;
        send(16'h9999);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = 16'h1234;
        step();
        check("busy_in_ready", 32'(ir[0]), 32'(0));
        in_valid = 1'b0;
        step();
        check("stall_valid", 32'(ov[0]), 32'(1));
        check("stall_data", 32'(od[0]), 32'(8'h39));
        step();
        out_ready = 1'b1;
        wait_idle();
        check_cap("frame9999", 6, 80'h3939_3939_0D0A);

        // Plan 6: asynchronous reset two bytes into a frame.
        send(16'h1987);
        step(); step();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_valid%0d", i), 32'(ov[i]), 32'(0));
            check($sformatf("async_ready%0d", i), 32'(ir[i]), 32'(1));
        end
        step(); step();
        rst_n = 1'b1;
        step();
        cap_n = 0;
        send(16'h3650);
        wait_idle();
        check_cap("frame3650", 6, 80'h3336_3530_0D0A);

        // Randomized traffic with zeros, invalid nibbles and backpressure.
        for (int c = 0; c < 600; c++) begin
            logic [15:0] w;
            for (int d = 0; d < 4; d++) begin
                int r;
                r = int'($urandom_range(0, 7));
                if (r < 4)       w[4*d +: 4] = 4'h0;
                else if (r == 4) w[4*d +: 4] = 4'(10 + $urandom_range(0, 5));
                else             w[4*d +: 4] = 4'(1 + $urandom_range(0, 8));
            end
            in_valid  = ($urandom_range(0, 2) == 0);
            in_bcd    = w;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_ascii_serializer.md
Name: bcd_ascii_serializer

Overview:
Transmit-side counterpart to the team's ASCII-to-BCD receive path. Accepts one packed BCD word of NDIG digits, most significant digit in the top nibble. Emits it as a byte stream of ASCII characters, MSD first, optionally followed by a CR/LF terminator. Sits between BCD arithmetic/counter logic and a byte-oriented sink (UART TX FIFO, display driver). Uses valid/ready handshakes on both sides.

Parameters:
NDIG, 4, number of BCD digits in in_bcd (range 1..8).
LZ_SUPPRESS, 1, 1 = leading zero digits are not emitted; the least significant digit is always emitted.
TERM_EN, 1, 1 = append 8'h0D then 8'h0A after the last digit.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  in_bcd holds a word to send.
in_ready  out  1  block can accept a word; high only in IDLE.
in_bcd  in  4*NDIG  packed BCD word, digit NDIG-1 in bits [4*NDIG-1 -: 4].
out_valid  out  1  out_data holds a byte.
out_ready  in  1  sink accepts the byte.
out_data  out  8  ASCII byte.
out_last  out  1  marks the final byte of the frame.
bcd_err  out  1  current byte came from an invalid nibble (>9).

Behaviour:
- One clock. Reset is asynchronous and active-low. Port names are clk and rst_n.
- Reset values: state=IDLE, out_valid=0, out_data=8'h00, out_last=0, bcd_err=0, in_ready=1. All inputs are ignored while rst_n=0.
- States: IDLE, DIGIT, TERM_CR, TERM_LF.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_bcd into a shift register;
  - compute the start digit index: the highest digit that is nonzero or invalid, or 0 if the word is all zero; with LZ_SUPPRESS=0 it is always NDIG-1;
  - go to DIGIT.
- Latency: out_valid rises the cycle after the input handshake, already carrying the first byte.
- DIGIT: out_data = 8'h30+nibble for nibbles 0..9; 8'h3F ('?') with bcd_err=1 for nibbles A..F.
  - Advance to the next lower digit only on out_valid&&out_ready.
  - After digit 0 is accepted: go to TERM_CR if TERM_EN, else go to IDLE.
- TERM_CR emits 8'h0D; TERM_LF emits 8'h0A. Each advances on handshake. TERM_LF returns to IDLE.
- out_last=1 on the final byte only: LF if TERM_EN, else digit 0.
- Backpressure: while out_valid&&!out_ready, out_data, out_last and bcd_err stay stable and state holds. No byte is dropped or repeated.
- out_valid falls the cycle after the final handshake; in_ready=1 in that same cycle. Maximum throughput is one byte per cycle inside a frame, plus one idle cycle between frames.
- in_valid while busy is ignored; the word is not captured.
- Invalid nibbles count as nonzero for leading-zero suppression. A '?' in the leading position is therefore always emitted.
- Reset mid-frame: the frame is aborted immediately and asynchronously and all outputs take their reset values. No partial-frame recovery.

Decomposition:
- Shared package: constants ASCII_ZERO=8'h30, ASCII_QMARK=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A; state enum typedef; function bcd_nibble_valid(nibble).
- One combinational sub-module, bcd_digit_to_ascii (4-bit nibble in; 8-bit byte and err out). It is instantiated once, on the current output digit. The same package constants serve the existing ASCII-to-BCD path.

Test Plan:
1. in_bcd=16'h1987, out_ready=1, defaults -> bytes 31,39,38,37,0D,0A on consecutive cycles; out_last only on 0A; in_ready=1 the cycle after.
2. in_bcd=16'h0042 with LZ_SUPPRESS=1 -> 34,32,0D,0A. Same word with LZ_SUPPRESS=0 -> 30,30,34,32,0D,0A.
3. in_bcd=16'h0000, LZ_SUPPRESS=1, TERM_EN=0 -> single byte 30 with out_last=1.
4. in_bcd=16'h1A99 -> 31,3F,39,39,0D,0A; bcd_err=1 only during the 3F byte. Separately, in_bcd=16'h0B00 -> 3F,30,30,0D,0A.
5. in_bcd=16'h9999 with out_ready held low 3 cycles while the second byte is presented -> out_data stays 39 and out_valid stays 1 throughout; exactly 6 bytes total. An in_valid pulse with 16'h1234 during the frame is not captured (in_ready=0).
6. Drop rst_n after 2 bytes of 16'h1987 -> out_valid=0 immediately without a clock edge. After release, in_ready=1; sending 16'h3650 yields 33,36,35,30,0D,0A.
